// File: rtl/pipe_dmem_pkg.sv
// pipe_dmem_pkg: FSM state type and sizing constants shared by the pipe_dmem_resp files
package pipe_dmem_pkg;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    localparam int LANES = 4;
    localparam int CNT_W = 4;
endpackage

// File: rtl/pipe_dmem_resp_if.sv
// pipe_dmem_resp_if: request/response bus between an initiator and pipe_dmem_resp
interface pipe_dmem_resp_if;
    import pipe_dmem_pkg::*;
    logic             req;
    logic             we;
    logic [31:0]      addr;
    logic [31:0]      wdata;
    logic [LANES-1:0] be;
    logic             ready;
    logic             rvalid;
    logic [31:0]      rdata;
    logic             err;
    modport master (output req, we, addr, wdata, be, input ready, rvalid, rdata, err);
    modport slave (input req, we, addr, wdata, be, output ready, rvalid, rdata, err);
endinterface

// File: rtl/pipe_dmem_bytemerge.sv
// pipe_dmem_bytemerge: replaces the byte lanes of a stored word selected by be with new write data
module pipe_dmem_bytemerge
    import pipe_dmem_pkg::*;
(
    input  logic [31:0]      old,
    input  logic [31:0]      wdata,
    input  logic [LANES-1:0] be,
    output logic [31:0]      merged
);
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign merged[8*i +: 8] = be[i] ? wdata[8*i +: 8] : old[8*i +: 8];
    end
endmodule

// File: rtl/pipe_dmem_resp.sv
// pipe_dmem_resp: data memory with fixed wait-state latency and one-cycle ready pulse.
// Define DMEM_RANGE_CHECK_EN to reject misaligned or out-of-range addresses with err.
module pipe_dmem_resp
    import pipe_dmem_pkg::*;
#(
    parameter int WAIT_CYCLES = 2,
    parameter int ADDR_W      = 6
) (
    input logic              clk,
    input logic              clrn,
    pipe_dmem_resp_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_W;

    state_t            state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [31:0]       mem [DEPTH];
    logic              acc_bad, cap_we, cap_bad, resp;
    logic [ADDR_W-1:0] cap_idx;
    logic [LANES-1:0]  cap_be;
    logic [31:0]       cap_wdata, rdata_q, merged;

`ifdef DMEM_RANGE_CHECK_EN
    assign acc_bad = (|bus.addr[1:0]) || (|bus.addr[31:ADDR_W+2]);
`else
    logic unused_addr;
    assign unused_addr = ^{bus.addr[1:0], bus.addr[31:ADDR_W+2]};
    assign acc_bad = 1'b0;
`endif

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        unique case (state)
            IDLE: if (bus.req) begin
                state_n = (WAIT_CYCLES > 0) ? WAIT : RESP;
                cnt_n   = (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;
            end
            WAIT: begin
                state_n = (cnt == '0) ? RESP : WAIT;
                cnt_n   = (cnt == '0) ? cnt : cnt - 1'b1;
            end
            RESP: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_ff @(posedge clk) begin
        if (state == IDLE && bus.req) begin
            cap_we    <= bus.we;
            cap_idx   <= bus.addr[ADDR_W+1:2];
            cap_wdata <= bus.wdata;
            cap_be    <= bus.be;
            cap_bad   <= acc_bad;
        end
    end

    pipe_dmem_bytemerge u_merge (
        .old    (mem[cap_idx]),
        .wdata  (cap_wdata),
        .be     (cap_be),
        .merged (merged)
    );

    // Memory only changes on the edge leaving RESP, so a reset before then aborts the write.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            rdata_q <= '0;
        end else if (resp && !cap_bad) begin
            if (cap_we) mem[cap_idx] <= merged;
            else rdata_q <= mem[cap_idx];
        end
    end

    assign resp       = state == RESP;
    assign bus.ready  = resp;
    assign bus.rvalid = resp && !cap_we && !cap_bad;
    assign bus.err    = resp && cap_bad;
    assign bus.rdata  = bus.rvalid ? mem[cap_idx] : rdata_q;
endmodule

// File: tb/tb_pipe_dmem_resp.sv
// tb_pipe_dmem_resp: scoreboard bench for pipe_dmem_resp with WAIT_CYCLES=2 and WAIT_CYCLES=0 instances
module tb_pipe_dmem_resp;
    logic clk = 1'b0;
    logic clrn = 1'b1;
    always #5 clk = ~clk;

    pipe_dmem_resp_if a();
    pipe_dmem_resp_if b();

    pipe_dmem_resp #(.WAIT_CYCLES(2), .ADDR_W(6)) dut  (.clk(clk), .clrn(clrn), .bus(a.slave));
    pipe_dmem_resp #(.WAIT_CYCLES(0), .ADDR_W(6)) dut0 (.clk(clk), .clrn(clrn), .bus(b.slave));

`ifdef DMEM_RANGE_CHECK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif

    typedef struct packed {
        logic [7:0]  lat;
        logic        rv;
        logic [31:0] rd;
        logic        e;
    } resp_t;

    typedef struct {
        logic        w;
        logic [31:0] ad;
        logic [31:0] wd;
        logic [3:0]  be;
        bit          chg;
        logic [31:0] rd;
        logic        e;
    } txn_t;

    resp_t       sb[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] last_rd = '0;

    task automatic exp_push(input logic w, input logic [31:0] data, input logic e, input int lat);
        resp_t r;
        r.lat = 8'(lat);
        r.e   = e;
        r.rv  = !w && !e;
        if (r.rv) last_rd = data;
        r.rd  = last_rd;
        sb.push_back(r);
    endtask

    // Drives one access on bus a and waits (bounded) for ready; optionally scrambles inputs mid-wait.
    task automatic do_acc(input txn_t t, output resp_t got);
        @(negedge clk);
        a.req = 1'b1; a.we = t.w; a.addr = t.ad; a.wdata = t.wd; a.be = t.be;
        got.lat = '0;
        do begin
            @(negedge clk);
            got.lat = got.lat + 1'b1;
            if (t.chg) begin
                a.addr  = t.ad + 32'h4;
                a.wdata = ~t.wd;
            end
        end while (!a.ready && got.lat < 8'd20);
        got.rv = a.rvalid;
        got.rd = a.rdata;
        got.e  = a.err;
        a.req  = 1'b0;
    endtask

    task automatic test_reset();
        #3 clrn = 1'b0;
        #4;
        checks++;
        if ({a.ready, a.rvalid, a.err, a.rdata} !== 35'h0) begin
            errors++;
            $display("FAIL reset_a got ready=%b rvalid=%b err=%b rdata=%h expected all 0", a.ready, a.rvalid, a.err, a.rdata);
        end
        checks++;
        if ({b.ready, b.rvalid, b.err, b.rdata} !== 35'h0) begin
            errors++;
            $display("FAIL reset_b got ready=%b rvalid=%b err=%b rdata=%h expected all 0", b.ready, b.rvalid, b.err, b.rdata);
        end
        @(negedge clk);
        clrn = 1'b1;
    endtask

    task automatic test_write_read();
        txn_t  t[2] = '{'{1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, 32'h0, 1'b0},
                        '{1'b0, 32'h10, 32'h0, 4'h0, 1'b0, 32'hDEADBEEF, 1'b0}};
        resp_t got, exp;
        for (int i = 0; i < 2; i++) begin
            exp_push(t[i].w, t[i].rd, t[i].e, 3);
            do_acc(t[i], got);
            exp = sb.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL write_read[%0d] got lat=%0d rv=%b rd=%h err=%b expected lat=%0d rv=%b rd=%h err=%b",
                         i, got.lat, got.rv, got.rd, got.e, exp.lat, exp.rv, exp.rd, exp.e);
            end
        end
    endtask

    task automatic test_byte_enable();
        txn_t  t[4] = '{'{1'b1, 32'h10, 32'h11223344, 4'b0101, 1'b0, 32'h0, 1'b0},
                        '{1'b0, 32'h10, 32'h0, 4'h0, 1'b0, 32'hDE22BE44, 1'b0},
                        '{1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000, 1'b0, 32'h0, 1'b0},
                        '{1'b0, 32'h10, 32'h0, 4'h0, 1'b0, 32'hDE22BE44, 1'b0}};
        resp_t got, exp;
        for (int i = 0; i < 4; i++) begin
            exp_push(t[i].w, t[i].rd, t[i].e, 3);
            do_acc(t[i], got);
            exp = sb.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL byte_enable[%0d] got lat=%0d rv=%b rd=%h err=%b expected lat=%0d rv=%b rd=%h err=%b",
                         i, got.lat, got.rv, got.rd, got.e, exp.lat, exp.rv, exp.rd, exp.e);
            end
        end
    endtask

    task automatic test_ignored_req();
        txn_t  t[3] = '{'{1'b1, 32'h30, 32'h55AA55AA, 4'hF, 1'b1, 32'h0, 1'b0},
                        '{1'b0, 32'h30, 32'h0, 4'h0, 1'b0, 32'h55AA55AA, 1'b0},
                        '{1'b0, 32'h34, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0}};
        resp_t got, exp;
        for (int i = 0; i < 3; i++) begin
            exp_push(t[i].w, t[i].rd, t[i].e, 3);
            do_acc(t[i], got);
            exp = sb.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL ignored_req[%0d] got lat=%0d rv=%b rd=%h err=%b expected lat=%0d rv=%b rd=%h err=%b",
                         i, got.lat, got.rv, got.rd, got.e, exp.lat, exp.rv, exp.rd, exp.e);
            end
        end
    endtask

    task automatic test_range();
        txn_t  t[4] = '{'{1'b1, 32'h0, 32'hCAFE0000, 4'hF, 1'b0, 32'h0, 1'b0},
                        '{1'b0, 32'h102, 32'h0, 4'h0, 1'b0, 32'hCAFE0000, RC},
                        '{1'b1, 32'h400, 32'h0BAD0400, 4'hF, 1'b0, 32'h0, RC},
                        '{1'b0, 32'h0, 32'h0, 4'h0, 1'b0, RC ? 32'hCAFE0000 : 32'h0BAD0400, 1'b0}};
        resp_t got, exp;
        for (int i = 0; i < 4; i++) begin
            exp_push(t[i].w, t[i].rd, t[i].e, 3);
            do_acc(t[i], got);
            exp = sb.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL range[%0d] got lat=%0d rv=%b rd=%h err=%b expected lat=%0d rv=%b rd=%h err=%b",
                         i, got.lat, got.rv, got.rd, got.e, exp.lat, exp.rv, exp.rd, exp.e);
            end
        end
    endtask

    task automatic test_reset_abort();
        txn_t  pre = '{1'b0, 32'h10, 32'h0, 4'h0, 1'b0, 32'hDE22BE44, 1'b0};
        txn_t  t[2] = '{'{1'b0, 32'h20, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0},
                        '{1'b0, 32'h10, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0}};
        resp_t got, exp;
        int    seen = 0;
        exp_push(pre.w, pre.rd, pre.e, 3);
        do_acc(pre, got);
        exp = sb.pop_front();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL abort_pre got lat=%0d rv=%b rd=%h err=%b expected lat=%0d rv=%b rd=%h err=%b",
                     got.lat, got.rv, got.rd, got.e, exp.lat, exp.rv, exp.rd, exp.e);
        end
        @(negedge clk);
        a.req = 1'b1; a.we = 1'b1; a.addr = 32'h20; a.wdata = 32'h12345678; a.be = 4'hF;
        @(negedge clk);
        a.req = 1'b0;
        #2 clrn = 1'b0;
        last_rd = '0;
        #1;
        checks++;
        if ({a.ready, a.rvalid, a.err, a.rdata} !== 35'h0) begin
            errors++;
            $display("FAIL abort_reset got ready=%b rvalid=%b err=%b rdata=%h expected all 0", a.ready, a.rvalid, a.err, a.rdata);
        end
        @(negedge clk);
        clrn = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (a.ready) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL abort_no_ready got %0d ready pulses expected 0", seen);
        end
        for (int i = 0; i < 2; i++) begin
            exp_push(t[i].w, t[i].rd, t[i].e, 3);
            do_acc(t[i], got);
            exp = sb.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL abort_read[%0d] got lat=%0d rv=%b rd=%h err=%b expected lat=%0d rv=%b rd=%h err=%b",
                         i, got.lat, got.rv, got.rd, got.e, exp.lat, exp.rv, exp.rd, exp.e);
            end
        end
    endtask

    // Zero-wait instance: request in each idle cycle, drop it in the ready cycle.
    task automatic test_zero_wait();
        resp_t got, exp;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (b.ready !== 1'b0) begin
                errors++;
                $display("FAIL zero_wait_idle[%0d] got ready=%b expected 0", i, b.ready);
            end
            b.req = 1'b1; b.we = (i == 0); b.addr = 32'hC; b.wdata = 32'hA5A50003; b.be = 4'hF;
            exp.lat = 8'd1;
            exp.rv  = (i != 0);
            exp.rd  = (i == 0) ? 32'h0 : 32'hA5A50003;
            exp.e   = 1'b0;
            sb.push_back(exp);
            @(negedge clk);
            got.lat = b.ready ? 8'd1 : 8'd0;
            got.rv  = b.rvalid;
            got.rd  = b.rdata;
            got.e   = b.err;
            b.req   = 1'b0;
            exp = sb.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL zero_wait[%0d] got ready=%0d rv=%b rd=%h err=%b expected ready=%0d rv=%b rd=%h err=%b",
                         i, got.lat, got.rv, got.rd, got.e, exp.lat, exp.rv, exp.rd, exp.e);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        a.req = 1'b0; a.we = 1'b0; a.addr = '0; a.wdata = '0; a.be = '0;
        b.req = 1'b0; b.we = 1'b0; b.addr = '0; b.wdata = '0; b.be = '0;
        test_reset();
        test_write_read();
        test_byte_enable();
        test_ignored_req();
        test_range();
        test_reset_abort();
        test_zero_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
